// File: rtl/display_scan.sv
// display_scan: two-digit multiplexed seven-segment scan controller.
// Latency: outputs are registered; each changes on the clk edge that enters a new state.
// Backpressure: none; free-running scan, inputs sampled only on entry to SHOW0.
//
// Optional feature macro: SCAN_BLANK_EN
//   defined   -> SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 (dark gap between digits)
//   undefined -> SHOW0 -> SHOW1 (BLANK parameter only affects counter sizing)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   s0, s1      hex values for digit 0 (right) and digit 1 (left)
//   digit       registered hex value for the downstream decoder
//   sel         registered mux select (0 = digit 0, 1 = digit 1)
//   an          registered active-low anode enables (an[0] = digit 0)
//   frame_start registered one-cycle pulse on the first cycle of each new SHOW0
module display_scan #(
  parameter int PERIOD = 24000,
  parameter int BLANK  = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] digit,
  output logic       sel,
  output logic [1:0] an,
  output logic       frame_start
);

  localparam int MAXLEN = (PERIOD > BLANK) ? PERIOD : BLANK;
  localparam int CW     = $clog2(MAXLEN);

  localparam logic [CW-1:0] SHOW_LOAD = CW'(PERIOD - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK - 1);
`endif

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    sh0, sh1, sh0_n, sh1_n;
  logic [3:0]    digit_n;
  logic          sel_n;
  logic [1:0]    an_n;
  logic          capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SHOW0;
      cnt         <= SHOW_LOAD;
      sh0         <= 4'h0;
      sh1         <= 4'h0;
      digit       <= 4'h0;
      sel         <= 1'b0;
      an          <= 2'b10;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sh0         <= sh0_n;
      sh1         <= sh1_n;
      digit       <= digit_n;
      sel         <= sel_n;
      an          <= an_n;
      frame_start <= capture;
    end
  end

  // Next state and counter: the counter runs down to zero, then the state
  // advances and the counter reloads with the length of the new state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt - CW'(1);
    if (cnt == '0) begin
      case (state)
`ifdef SCAN_BLANK_EN
        SHOW0:   state_n = BLANK0;
        BLANK0:  state_n = SHOW1;
        SHOW1:   state_n = BLANK1;
        BLANK1:  state_n = SHOW0;
        default: state_n = SHOW0;
`else
        SHOW0:   state_n = SHOW1;
        SHOW1:   state_n = SHOW0;
        default: state_n = SHOW0;
`endif
      endcase
`ifdef SCAN_BLANK_EN
      cnt_n = (state_n == SHOW0 || state_n == SHOW1) ? SHOW_LOAD : BLANK_LOAD;
`else
      cnt_n = SHOW_LOAD;
`endif
    end
  end

  // Outputs are decoded from the next state so they register on the same
  // edge as the state change. The post-reset SHOW0 is not an "entry", so
  // the first capture happens only at the end of the first frame.
  always_comb begin
    capture = (state_n == SHOW0) && (state != SHOW0);
    sh0_n   = capture ? s0 : sh0;
    sh1_n   = capture ? s1 : sh1;

    an_n  = 2'b11;
    sel_n = 1'b0;
    case (state_n)
      SHOW0:   begin an_n = 2'b10; sel_n = 1'b0; end
      BLANK0:  begin an_n = 2'b11; sel_n = 1'b1; end
      SHOW1:   begin an_n = 2'b01; sel_n = 1'b1; end
      BLANK1:  begin an_n = 2'b11; sel_n = 1'b0; end
      default: begin an_n = 2'b11; sel_n = 1'b0; end
    endcase

    digit_n = sel_n ? sh1_n : sh0_n;
  end

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

  localparam int P = 4;
  localparam int B = 2;
`ifdef SCAN_BLANK_EN
  localparam int F  = 2 * P + 2 * B;
  localparam int S1 = P + B;
`else
  localparam int F  = 2 * P;
  localparam int S1 = P;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] s0    = 4'h3;
  logic [3:0] s1    = 4'hA;
  logic [3:0] digit;
  logic       sel;
  logic [1:0] an;
  logic       frame_start;

  int checks   = 0;
  int failures = 0;

  display_scan #(.PERIOD(P), .BLANK(B)) dut (
    .clk         (clk),
    .reset       (reset),
    .s0          (s0),
    .s1          (s1),
    .digit       (digit),
    .sel         (sel),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Model: t counts cycles since reset release; the frame position decides
  // which digit is lit, and values are latched at every frame boundary.
  int         t   = 0;
  logic [3:0] m0  = 4'h0;
  logic [3:0] m1  = 4'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t  = 0;
      m0 = 4'h0;
      m1 = 4'h0;
    end else begin
      t = t + 1;
      if (t % F == 0) begin
        m0 = s0;
        m1 = s1;
      end
    end
  end

  // Returns {an, sel, digit, frame_start}.
  function automatic logic [7:0] model_out(input int tt, input logic [3:0] v0, input logic [3:0] v1);
    int         p;
    logic [1:0] e_an;
    logic       e_sel;
    p = tt % F;
`ifdef SCAN_BLANK_EN
    if (p < P)              begin e_an = 2'b10; e_sel = 1'b0; end
    else if (p < P + B)     begin e_an = 2'b11; e_sel = 1'b1; end
    else if (p < 2 * P + B) begin e_an = 2'b01; e_sel = 1'b1; end
    else                    begin e_an = 2'b11; e_sel = 1'b0; end
`else
    if (p < P) begin e_an = 2'b10; e_sel = 1'b0; end
    else       begin e_an = 2'b01; e_sel = 1'b1; end
`endif
    return {e_an, e_sel, (e_sel ? v1 : v0), (p == 0 && tt > 0)};
  endfunction

  logic prev_ok  = 1'b0;
  logic prev_sel = 1'b0;

  always @(negedge clk) begin
    logic [7:0] exp_v;
    logic [7:0] act_v;
    act_v = {an, sel, digit, frame_start};
    exp_v = reset ? 8'b10_0_0000_0 : model_out(t, m0, m1);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL cycle_compare t=%0d reset=%0b actual an=%b sel=%b digit=%h fs=%b required an=%b sel=%b digit=%h fs=%b",
               t, reset, act_v[7:6], act_v[5], act_v[4:1], act_v[0],
               exp_v[7:6], exp_v[5], exp_v[4:1], exp_v[0]);
    end
    checks++;
    if (an === 2'b00) begin
      failures++;
      $display("FAIL an_never_00 t=%0d actual an=%b required not 00", t, an);
    end
`ifdef SCAN_BLANK_EN
    if (prev_ok && sel !== prev_sel) begin
      checks++;
      if (an !== 2'b11) begin
        failures++;
        $display("FAIL sel_change_while_lit t=%0d actual an=%b required 11", t, an);
      end
    end
`endif
    prev_ok  = !reset;
    prev_sel = sel;
  end

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, req);
    end
  endtask

  task automatic wait_t(input int target);
    int g;
    g = 0;
    while (t != target && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (t != target) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout actual t=%0d required t=%0d", t, target);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // First frame shows zeros with the full SHOW0 length.
    wait_t(0);
    check_val("first_an", an, 2'b10);
    check_val("first_digit", digit, 0);
    check_val("first_fs", frame_start, 0);
`ifdef SCAN_BLANK_EN
    wait_t(4);
    check_val("blank0_an", an, 2'b11);
    check_val("blank0_sel", sel, 1);
`endif
    wait_t(S1);
    check_val("show1_an", an, 2'b01);
    check_val("show1_digit_zero", digit, 0);

    // Second frame: captured 3 / A.
    wait_t(F);
    check_val("frame2_fs", frame_start, 1);
    check_val("frame2_digit", digit, 4'h3);
    check_val("frame2_an", an, 2'b10);
    wait_t(F + 1);
    check_val("frame2_fs_drop", frame_start, 0);
    wait_t(F + S1);
    check_val("frame2_digit1", digit, 4'hA);

    // Change s0 two cycles into SHOW1; it must not show until next frame.
    wait_t(F + S1 + 2);
    s0 = 4'h7;
`ifdef SCAN_BLANK_EN
    wait_t(F + 10);
    check_val("blank1_old_digit", digit, 4'h3);
    check_val("blank1_sel", sel, 0);
`endif
    wait_t(2 * F);
    check_val("frame3_digit", digit, 4'h7);
    check_val("frame3_fs", frame_start, 1);

    // Asynchronous reset in the middle of SHOW1.
    wait_t(2 * F + S1 + 2);
    check_val("pre_reset_sel", sel, 1);
    #1 reset = 1'b1;
    #1;
    check_val("async_an", an, 2'b10);
    check_val("async_sel", sel, 0);
    check_val("async_digit", digit, 0);
    check_val("async_fs", frame_start, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    wait_t(0);
    check_val("rerel_digit", digit, 0);
    wait_t(3);
    check_val("rerel_show0_last", an, 2'b10);
    wait_t(4);
`ifdef SCAN_BLANK_EN
    check_val("rerel_show0_end", an, 2'b11);
`else
    check_val("rerel_show0_end", an, 2'b01);
`endif
    wait_t(F);
    check_val("rerel_capture", digit, 4'h7);
    check_val("rerel_fs", frame_start, 1);
    wait_t(2 * F);
    check_val("rerel_fs2", frame_start, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter PERIOD, default 24000, number of clk cycles each digit is lit (SHOW state length); legal range >= 2.
REQ-002 Parameter BLANK, default 240, number of clk cycles both digits are dark between digits (BLANK state length); legal range >= 1.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port s0  input  4  hex value for digit 0 (right).
REQ-006 Port s1  input  4  hex value for digit 1 (left).
REQ-007 Port digit  output  4  registered hex value to the downstream 2:1 mux/seven-segment decoder path.
REQ-008 Port sel  output  1  registered mux select; 0 = digit 0 path, 1 = digit 1 path.
REQ-009 Port an  output  2  registered active-low common-anode enables; an[0] = digit 0, an[1] = digit 1.
REQ-010 Port frame_start  output  1  registered one-cycle pulse on the first cycle of each SHOW0.

Function
REQ-011 The FSM SHALL have states SHOW0, BLANK0, SHOW1 and BLANK1, plus a down-counter of width $clog2(max(PERIOD,BLANK)).
REQ-012 SHOW0 and SHOW1 SHALL each last exactly PERIOD cycles; BLANK0 and BLANK1 SHALL each last exactly BLANK cycles.
REQ-013 Transition order SHALL be SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0, repeating without stalls; frame length = 2*PERIOD + 2*BLANK cycles.
REQ-014 an SHALL be 2'b10 in SHOW0, 2'b01 in SHOW1 and 2'b11 in both BLANK states; an SHALL never be 2'b00.
REQ-015 sel SHALL be 0 in SHOW0 and BLANK1 and 1 in SHOW1 and BLANK0, so sel changes only while both anodes are off.
REQ-016 On the edge entering SHOW0, shadow registers SHALL capture s0 and s1; s0/s1 changes at any other time SHALL have no effect until the next frame.
REQ-017 digit SHALL equal shadow s0 when sel = 0 and shadow s1 when sel = 1, updated on the same edge as sel.
REQ-018 frame_start SHALL be high for exactly the first cycle of each SHOW0 entered from BLANK1 (or from SHOW1 when blanking is compiled out), and low otherwise.
REQ-019 The counter SHALL reload on every state change; it SHALL NOT wrap or skip, and no state SHALL be shortened or lengthened by input activity.

Reset
REQ-020 While reset is high, regardless of clk: state = SHOW0, counter = PERIOD-1, shadow registers = 0, digit = 4'h0, sel = 0, an = 2'b10, frame_start = 0.
REQ-021 A reset asserted mid-frame SHALL take effect immediately; after deassertion, the first SHOW0 SHALL last the full PERIOD cycles and display 0.
REQ-022 The first capture of s0/s1 SHALL occur on the first entry to SHOW0 after the post-reset frame.

Configuration
REQ-023 Macro SCAN_BLANK_EN, when defined, SHALL compile in the BLANK0/BLANK1 states and the BLANK parameter as specified above.
REQ-024 When SCAN_BLANK_EN is undefined, transitions SHALL be SHOW0 -> SHOW1 -> SHOW0 with frame length 2*PERIOD; sel SHALL change on the same edge as an; capture and frame_start SHALL occur on entry to SHOW0 from SHOW1; BLANK SHALL be ignored.

Verification (PERIOD=4, BLANK=2 unless noted)
REQ-025 SCAN_BLANK_EN defined, s0=4'h3, s1=4'hA, release reset -> an=10 for 4 cycles, 11 for 2, 01 for 4, 11 for 2; frame repeats every 12 cycles.
REQ-026 Same run -> digit=0 during the first frame; from cycle 12 on, digit=3 in SHOW0/BLANK1 and A in SHOW1/BLANK0; frame_start pulses at cycles 12, 24, 36.
REQ-027 Change s0 from 4'h3 to 4'h7 two cycles into SHOW1 -> digit remains 3 until the next SHOW0, then becomes 7.
REQ-028 Assert reset asynchronously midway through SHOW1 -> an=10, sel=0, digit=0 before the next clk edge; held for 4 cycles after deassertion.
REQ-029 SCAN_BLANK_EN undefined -> an alternates 10/01 every 4 cycles; an=11 never occurs; frame_start every 8 cycles.
REQ-030 All runs -> checker asserts an!=2'b00 and that sel never changes while an!=2'b11 (blanking build only).
